// File: rtl/sr_latch_driver.sv
// sr_latch_driver
// Clocked initiator for an enable-gated SR latch with a latch reset input.
// A command (clear / set / latch reset) is accepted over valid/ready, the
// latch drives are sequenced through SETUP -> PULSE -> HOLD, and the latch
// outputs are read back to confirm the write. All outputs are registered and
// the drive pattern never presents S=R=1 or en together with lat_reset.
module sr_latch_driver #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_op,
    output logic       req_ready,
    output logic       S,
    output logic       R,
    output logic       en,
    output logic       lat_reset,
    input  logic       q_in,
    input  logic       q_n_in,
    output logic       done,
    output logic       err,
    output logic [7:0] err_cnt
);

    // A zero pulse width still needs one enable cycle to write the latch.
    localparam int PULSE_LEN = (PULSE_CYC < 1) ? 1 : PULSE_CYC;

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_LRST  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        CHECK
    } state_t;

    state_t           state;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt;
    logic             chk_err;

    // Error counter increment that sticks at full scale instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Readback is bad if Q disagrees with the written value, if Q and Q_n
    // are not complementary, or if the command itself was reserved.
    function automatic logic readback_err(input logic [1:0] op,
                                          input logic       q,
                                          input logic       qn);
        return (op == OP_RSVD) || (q != (op == OP_SET)) || (q == qn);
    endfunction

    // The readback is taken on the edge that enters CHECK so that err,
    // err_cnt and done all become visible together during the CHECK cycle.
    assign chk_err = readback_err(op_q, q_in, q_n_in);

    // Command sequencer: state, phase counter and every registered drive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            op_q      <= OP_CLEAR;
            cnt       <= '0;
            req_ready <= 1'b0;
            S         <= 1'b0;
            R         <= 1'b0;
            en        <= 1'b0;
            lat_reset <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    S         <= 1'b0;
                    R         <= 1'b0;
                    en        <= 1'b0;
                    lat_reset <= 1'b0;
                    if (req_valid && req_ready) begin
                        op_q      <= req_op;
                        req_ready <= 1'b0;
                        if (req_op == OP_RSVD) begin
                            // Reserved op: no latch activity, report at once.
                            state   <= CHECK;
                            done    <= 1'b1;
                            err     <= 1'b1;
                            err_cnt <= sat_inc(err_cnt);
                        end else if (SETUP_CYC > 0) begin
                            state <= SETUP;
                            cnt   <= SETUP_LAST;
                            S     <= (req_op == OP_SET);
                            R     <= (req_op == OP_CLEAR);
                        end else begin
                            state     <= PULSE;
                            cnt       <= PULSE_LAST;
                            S         <= (req_op == OP_SET);
                            R         <= (req_op == OP_CLEAR);
                            en        <= (req_op != OP_LRST);
                            lat_reset <= (req_op == OP_LRST);
                        end
                    end
                end

                SETUP: begin
                    if (cnt == '0) begin
                        state     <= PULSE;
                        cnt       <= PULSE_LAST;
                        en        <= (op_q != OP_LRST);
                        lat_reset <= (op_q == OP_LRST);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                PULSE: begin
                    if (cnt == '0) begin
                        en        <= 1'b0;
                        lat_reset <= 1'b0;
                        if (HOLD_CYC > 0) begin
                            state <= HOLD;
                            cnt   <= HOLD_LAST;
                        end else begin
                            state <= CHECK;
                            S     <= 1'b0;
                            R     <= 1'b0;
                            done  <= 1'b1;
                            err   <= chk_err;
                            if (chk_err) begin
                                err_cnt <= sat_inc(err_cnt);
                            end
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                HOLD: begin
                    if (cnt == '0) begin
                        state <= CHECK;
                        S     <= 1'b0;
                        R     <= 1'b0;
                        done  <= 1'b1;
                        err   <= chk_err;
                        if (chk_err) begin
                            err_cnt <= sat_inc(err_cnt);
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                CHECK: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                    S         <= 1'b0;
                    R         <= 1'b0;
                    en        <= 1'b0;
                    lat_reset <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Testbench for sr_latch_driver: a default-parameter instance and a
// zero-timing instance, each wired to a behavioural SR latch, driven with
// directed and randomized commands and compared against a timeline model.
module tb_sr_latch_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       rv;
    logic [1:0] rop;
    int         sel;
    int         fmode;
    logic       fq;

    logic       a_valid, a_ready, a_S, a_R, a_en, a_lr, a_qin, a_qn, a_done, a_err;
    logic [7:0] a_cnt;
    logic       b_valid, b_ready, b_S, b_R, b_en, b_lr, b_qin, b_qn, b_done, b_err;
    logic [7:0] b_cnt;
    logic       a_lq = 1'b0;
    logic       b_lq = 1'b0;

    logic       c_ready, c_S, c_R, c_en, c_lr, c_done, c_err;
    logic [7:0] c_cnt;

    int checks = 0;
    int errors = 0;

    // Model state: latch value each driver should have written, error counts.
    logic mq [2];
    int   ecnt [2];
    int   su_t [2];
    int   pl_t [2];
    int   ho_t [2];

    assign a_valid = rv && (sel == 0);
    assign b_valid = rv && (sel == 1);

    sr_latch_driver dut (
        .clk(clk), .reset(reset), .req_valid(a_valid), .req_op(rop),
        .req_ready(a_ready), .S(a_S), .R(a_R), .en(a_en), .lat_reset(a_lr),
        .q_in(a_qin), .q_n_in(a_qn), .done(a_done), .err(a_err), .err_cnt(a_cnt)
    );

    sr_latch_driver #(.SETUP_CYC(0), .PULSE_CYC(0), .HOLD_CYC(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(b_valid), .req_op(rop),
        .req_ready(b_ready), .S(b_S), .R(b_R), .en(b_en), .lat_reset(b_lr),
        .q_in(b_qin), .q_n_in(b_qn), .done(b_done), .err(b_err), .err_cnt(b_cnt)
    );

    // Behavioural latches, updated mid-cycle from the registered drives.
    always @(negedge clk) begin
        if (a_lr) a_lq <= 1'b0;
        else if (a_en && a_S) a_lq <= 1'b1;
        else if (a_en && a_R) a_lq <= 1'b0;
        if (b_lr) b_lq <= 1'b0;
        else if (b_en && b_S) b_lq <= 1'b1;
        else if (b_en && b_R) b_lq <= 1'b0;
    end

    // Readback path with optional fault injection (forced Q, or Q=Q_n=1).
    assign a_qin = (fmode == 0) ? a_lq  : (fmode == 1) ? fq  : 1'b1;
    assign a_qn  = (fmode == 0) ? ~a_lq : (fmode == 1) ? ~fq : 1'b1;
    assign b_qin = (fmode == 0) ? b_lq  : (fmode == 1) ? fq  : 1'b1;
    assign b_qn  = (fmode == 0) ? ~b_lq : (fmode == 1) ? ~fq : 1'b1;

    assign c_ready = (sel == 1) ? b_ready : a_ready;
    assign c_S     = (sel == 1) ? b_S     : a_S;
    assign c_R     = (sel == 1) ? b_R     : a_R;
    assign c_en    = (sel == 1) ? b_en    : a_en;
    assign c_lr    = (sel == 1) ? b_lr    : a_lr;
    assign c_done  = (sel == 1) ? b_done  : a_done;
    assign c_err   = (sel == 1) ? b_err   : a_err;
    assign c_cnt   = (sel == 1) ? b_cnt   : a_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one command to the selected driver and check every cycle up to
    // completion against a timeline derived from the phase lengths.
    task automatic run_cmd(input logic [1:0] op, input int mode, input logic fqv, input bit junk);
        int   s, p, h, d, w;
        logic q, qn;
        bit   xerr;
        s = su_t[sel];
        p = pl_t[sel];
        h = ho_t[sel];
        d = (op == 2'b11) ? 1 : s + p + h + 1;
        w = 0;
        while (!c_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", c_ready, 1);
        fmode = mode;
        fq    = fqv;
        rv    = 1'b1;
        rop   = op;
        @(posedge clk);
        if (op == 2'b01) mq[sel] = 1'b1;
        else if (op != 2'b11) mq[sel] = 1'b0;
        q    = (mode == 0) ? mq[sel]  : (mode == 1) ? fqv  : 1'b1;
        qn   = (mode == 0) ? ~mq[sel] : (mode == 1) ? ~fqv : 1'b1;
        xerr = (op == 2'b11) || (q != (op == 2'b01)) || (q == qn);
        if (xerr && ecnt[sel] < 255) ecnt[sel]++;
        for (int t = 1; t <= d; t++) begin
            @(negedge clk);
            check("S",         c_S,     (op == 2'b01) && t < d);
            check("R",         c_R,     (op == 2'b00) && t < d);
            check("en",        c_en,    (op < 2'b10) && t > s && t <= s + p);
            check("lat_reset", c_lr,    (op == 2'b10) && t > s && t <= s + p);
            check("done",      c_done,  t == d);
            check("err",       c_err,   (t == d) && xerr);
            check("busy",      c_ready, 0);
            if (t == d) check("err_cnt", c_cnt, ecnt[sel]);
            rv  = (junk && t < d) ? 1'($urandom_range(0, 1)) : 1'b0;
            rop = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        check("ready_after", c_ready, 1);
        check("done_after",  c_done,  0);
        check("err_after",   c_err,   0);
        check("cnt_after",   c_cnt,   ecnt[sel]);
        fmode = 0;
    endtask

    initial begin
        su_t = '{1, 0};
        pl_t = '{2, 1};
        ho_t = '{1, 0};
        mq   = '{1'b0, 1'b0};
        ecnt = '{0, 0};
        sel   = 0;
        fmode = 0;
        fq    = 1'b0;
        rv    = 1'b0;
        rop   = 2'b00;
        reset = 1'b0;

        // Reset state of both instances.
        repeat (2) @(negedge clk);
        check("rst_ready", a_ready, 0);
        check("rst_drive", {a_S, a_R, a_en, a_lr}, 0);
        check("rst_flags", {a_done, a_err}, 0);
        check("rst_cnt",   a_cnt, 0);
        check("rst_ready0", b_ready, 0);
        reset = 1'b1;
        #1 check("ready_pre_edge", a_ready, 0);
        @(posedge clk);
        #1 check("ready_first_edge", a_ready, 1);
        check("ready_first_edge0", b_ready, 1);
        @(negedge clk);

        // Set, clear, forced-wrong clear, latch reset, bad readback, reserved.
        run_cmd(2'b01, 0, 1'b0, 1'b0);
        run_cmd(2'b00, 0, 1'b0, 1'b0);
        run_cmd(2'b00, 1, 1'b1, 1'b0);
        run_cmd(2'b10, 0, 1'b0, 1'b0);
        run_cmd(2'b10, 2, 1'b0, 1'b0);
        run_cmd(2'b11, 0, 1'b0, 1'b0);

        // Randomized commands with occasional readback faults and busy noise.
        for (int i = 0; i < 25; i++) begin
            run_cmd(2'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
                    1'($urandom_range(0, 1)), 1'b1);
        end

        // Asynchronous reset while en is high.
        sel = 0;
        rv  = 1'b1;
        rop = 2'b01;
        @(posedge clk);
        @(negedge clk);
        rv = 1'b0;
        @(negedge clk);
        check("pulse_en", a_en, 1);
        #2 reset = 1'b0;
        #1;
        check("abort_S",     a_S, 0);
        check("abort_en",    a_en, 0);
        check("abort_R",     a_R, 0);
        check("abort_ready", a_ready, 0);
        check("abort_cnt",   a_cnt, 0);
        check("abort_cnt0",  b_cnt, 0);
        ecnt = '{0, 0};
        mq[0] = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1 check("rel_ready_pre", a_ready, 0);
        @(posedge clk);
        #1 check("rel_ready", a_ready, 1);
        @(negedge clk);
        run_cmd(2'b00, 0, 1'b0, 1'b0);

        // Zero-timing instance and error counter saturation.
        sel = 1;
        run_cmd(2'b01, 0, 1'b0, 1'b0);
        run_cmd(2'b00, 0, 1'b0, 1'b0);
        run_cmd(2'b10, 0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            run_cmd(2'($urandom_range(0, 3)), 2, 1'b0, 1'b1);
        end
        check("sat_cnt", b_cnt, 255);
        check("other_cnt", a_cnt, ecnt[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
